// File: rtl/pid_incr_seq.sv
// Incremental PID sequencer: one shared signed multiplier walks P, I, D terms
// over three cycles, then folds du into the saturated controller output.
module pid_incr_seq #(
  parameter int DW   = 12,
  parameter int KW   = 12,
  parameter int FRAC = 8,
  parameter int AW   = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic signed [DW-1:0] target,
  input  logic signed [DW-1:0] y,
  input  logic signed [KW-1:0] kp,
  input  logic signed [KW-1:0] ki,
  input  logic signed [KW-1:0] kd,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] u_out
);

  localparam int OW = DW + 2;
  localparam int PW = OW + KW;

  localparam logic signed [DW-1:0] E_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] E_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [AW-1:0] U_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] U_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, S_P, S_I, S_D, S_UPD} state_t;

  state_t               state;
  logic signed [DW-1:0] e0, e1, e2;
  logic signed [KW-1:0] kp_r, ki_r, kd_r;
  logic signed [AW-1:0] acc;

  // Error at DW+1 bits so target - y never wraps before clamping.
  logic signed [DW:0]   diff;
  logic signed [DW-1:0] e_sat;

  assign diff = {target[DW-1], target} - {y[DW-1], y};

  always_comb begin
    e_sat = diff[DW-1:0];
    if (diff[DW] != diff[DW-1])
      e_sat = diff[DW] ? E_MIN : E_MAX;
  end

  // Multiplier operands, all widened to DW+2 so the second difference fits.
  logic signed [OW-1:0] e0_x, e1_x, e2_x;
  logic signed [OW-1:0] op;
  logic signed [KW-1:0] gain;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_x;

  assign e0_x = {{2{e0[DW-1]}}, e0};
  assign e1_x = {{2{e1[DW-1]}}, e1};
  assign e2_x = {{2{e2[DW-1]}}, e2};

  always_comb begin
    op   = '0;
    gain = '0;
    case (state)
      S_P: begin op = e0_x - e1_x;                    gain = kp_r; end
      S_I: begin op = e0_x;                           gain = ki_r; end
      S_D: begin op = e0_x - (e1_x <<< 1) + e2_x;     gain = kd_r; end
      default: ;
    endcase
  end

  assign prod   = op * gain;
  assign prod_x = {{(AW-PW){prod[PW-1]}}, prod};

  // Arithmetic shift floors du; the sum is formed at AW bits before clamping.
  logic signed [AW-1:0] du, u_sum;
  logic signed [DW-1:0] u_sat;

  assign du    = acc >>> FRAC;
  assign u_sum = {{(AW-DW){u_out[DW-1]}}, u_out} + du;

  always_comb begin
    u_sat = u_sum[DW-1:0];
    if (u_sum > U_MAX)      u_sat = U_MAX[DW-1:0];
    else if (u_sum < U_MIN) u_sat = U_MIN[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      u_out <= '0;
      e0    <= '0;
      e1    <= '0;
      e2    <= '0;
      acc   <= '0;
      kp_r  <= '0;
      ki_r  <= '0;
      kd_r  <= '0;
    end else if (clear) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      u_out <= '0;
      e1    <= '0;
      e2    <= '0;
      acc   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          e0    <= e_sat;
          kp_r  <= kp;
          ki_r  <= ki;
          kd_r  <= kd;
          busy  <= 1'b1;
          state <= S_P;
        end
        S_P: begin
          acc   <= prod_x;
          state <= S_I;
        end
        S_I: begin
          acc   <= acc + prod_x;
          state <= S_D;
        end
        S_D: begin
          acc   <= acc + prod_x;
          state <= S_UPD;
        end
        S_UPD: begin
          u_out <= u_sat;
          e2    <= e1;
          e1    <= e0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_incr_seq.sv
// Bench for pid_incr_seq: per-sample arithmetic model checked every cycle,
// plus directed samples with hand-computed u_out values.
module tb_pid_incr_seq;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               clear = 1'b0;
  logic signed [11:0] target = '0, y = '0;
  logic signed [11:0] kp = '0, ki = '0, kd = '0;
  logic               busy, done;
  logic signed [11:0] u_out;

  int total = 0;
  int bad   = 0;

  pid_incr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .target(target), .y(y), .kp(kp), .ki(ki), .kd(kd),
    .busy(busy), .done(done), .u_out(u_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic longint sat12(input longint v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Whole-sample result: u(k) = sat(u(k-1) + floor(sum/2^8)).
  function automatic longint next_u(input longint u, e0, e1, e2, p, i, d);
    longint acc;
    acc = p * (e0 - e1) + i * e0 + d * (e0 - 2 * e1 + e2);
    return sat12(u + (acc >>> 8));
  endfunction

  // Model: a sample is accepted when idle, and its result appears 4 edges later.
  int     m_left;
  logic   m_busy, m_done;
  longint m_u, m_e0, m_e1, m_e2, m_nu;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_u <= 0; m_e0 <= 0; m_e1 <= 0; m_e2 <= 0; m_nu <= 0;
    end else if (clear) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_u <= 0; m_e1 <= 0; m_e2 <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_e0   <= sat12(longint'(target) - longint'(y));
          m_nu   <= next_u(m_u, sat12(longint'(target) - longint'(y)), m_e1, m_e2,
                           longint'(kp), longint'(ki), longint'(kd));
          m_left <= 4;
          m_busy <= 1'b1;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_u    <= m_nu;
          m_e2   <= m_e1;
          m_e1   <= m_e0;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", longint'(busy), longint'(m_busy));
    chk("cyc_done", longint'(done), longint'(m_done));
    chk("cyc_u",    longint'(u_out), m_u);
  end

  task automatic run_sample(input string nm, input int tg, input int yy,
                            input int p, input int i, input int d, input int exp_u);
    int n;
    @(negedge clk);
    target = 12'(tg); y = 12'(yy); kp = 12'(p); ki = 12'(i); kd = 12'(d);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, 4);
    chk({nm, "_u"}, longint'(u_out), exp_u);
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  initial begin
    int dn, first_k, prev_k, gap_bad;

    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_u",    longint'(u_out), 0);
    rst_n = 1'b1;

    // T1: pure P term
    run_sample("t1a", 100, 0, 256, 0, 0, 100);
    run_sample("t1b", 100, 0, 256, 0, 0, 100);

    // T2: integral accumulation and a negative step
    do_clear();
    run_sample("t2a", 10, 0, 0, 128, 0, 5);
    run_sample("t2b", 10, 0, 0, 128, 0, 10);
    run_sample("t2c", 10, 0, 0, 128, 0, 15);
    run_sample("t2d", 0, 1, 0, 128, 0, 14);

    // T3: error and output saturation
    do_clear();
    run_sample("t3a", 2047, -2048, 2047, 0, 0, 2047);
    run_sample("t3b", -2048, 2047, 2047, 0, 0, -2048);

    // T4: derivative on the second difference
    do_clear();
    run_sample("t4a", 0,  0, 0, 0, 256, 0);
    run_sample("t4b", 0,  0, 0, 0, 256, 0);
    run_sample("t4c", 50, 0, 0, 0, 256, 50);
    run_sample("t4d", 50, 0, 0, 0, 256, 0);

    // T5: start held high for 12 edges
    do_clear();
    @(negedge clk);
    target = 12'sd7; y = '0; kp = 12'sd256; ki = '0; kd = '0;
    start = 1'b1;
    dn = 0; first_k = -1; prev_k = -1; gap_bad = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (first_k < 0) first_k = k;
        if (prev_k >= 0 && k - prev_k != 5) gap_bad++;
        prev_k = k;
      end
      if (k == 12) start = 1'b0;
    end
    chk("t5_done_count", dn, 3);
    chk("t5_first_done", first_k, 5);
    chk("t5_gap", gap_bad, 0);
    chk("t5_u", longint'(u_out), 7);

    // T6a: clear during S_I
    do_clear();
    run_sample("t6_pre", 30, 0, 256, 0, 0, 30);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    dn = 0;
    repeat (6) begin @(negedge clk); if (done) dn++; end
    chk("t6a_no_done", dn, 0);
    chk("t6a_u", longint'(u_out), 0);
    run_sample("t6a_next", 30, 0, 256, 0, 0, 30);

    // T6b: reset during S_D
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    dn = 0;
    repeat (6) begin @(negedge clk); if (done) dn++; end
    chk("t6b_no_done", dn, 0);
    chk("t6b_u", longint'(u_out), 0);
    run_sample("t6b_next", 30, 0, 256, 0, 0, 30);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
